tx_fifo_ctrl: RTL and testbench
===============================

# tx_fifo_ctrl

Single-clock controller for the TX FIFO memory. Arbitrates two write requesters onto the memory's single write port with round-robin fairness. Owns the write and read pointers and presents a valid/ready read interface to the downstream TX consumer. Sits between the protocol-layer and retry/replay flit sources and the FIFO memory instance, which it drives directly.

## Interface
Parameters:
- FIFO_DEPTH, 8, number of entries; power of two, ≥2
- DATA_WIDTH, 8, entry width in bits
- AF_THRESHOLD, FIFO_DEPTH-2, almost-full level in entries; used only with TX_FIFO_CTRL_ALMOST_FULL_EN

Ports (AW = $clog2(FIFO_DEPTH)):
- w_clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has data
- req0_data  in  DATA_WIDTH  requester 0 data
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has data
- req1_data  in  DATA_WIDTH  requester 1 data
- req1_ready  out  1  requester 1 accepted this cycle
- mem_w_en  out  1  memory write enable
- mem_w_addr  out  AW  memory write address
- mem_w_data  out  DATA_WIDTH  memory write data
- mem_r_addr  out  AW  memory read address
- mem_r_data  in  DATA_WIDTH  memory read data; combinational from mem_r_addr
- rd_valid  out  1  head entry available
- rd_data  out  DATA_WIDTH  head entry
- rd_ready  in  1  consumer takes head this cycle
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- count  out  AW+1  current occupancy
- almost_full  out  1  present only with TX_FIFO_CTRL_ALMOST_FULL_EN

## Operation
- State: wr_ptr, rd_ptr (AW+1 bits each, MSB is wrap bit), last_grant (1 bit).
- count = wr_ptr - rd_ptr, modulo 2^(AW+1). full when MSBs differ and low bits are equal. empty when pointers are equal.
- Arbitration (combinational):
  - Only req0_valid asserted: grant 0.
  - Only req1_valid asserted: grant 1.
  - Both asserted: grant the requester not equal to last_grant.
  - No grant while full, even if a pop occurs in the same cycle.
- reqN_ready = grant==N & !full; at most one ready is high per cycle.
- Push = any reqN_valid & reqN_ready. On push:
  - mem_w_en=1, mem_w_addr=wr_ptr[AW-1:0], mem_w_data = granted data.
  - wr_ptr increments; last_grant takes the granted index.
- When there is no push, mem_w_en=0 and last_grant holds.
- mem_r_addr = rd_ptr[AW-1:0]; rd_data = mem_r_data; rd_valid = !empty.
- Pop = rd_valid & rd_ready; rd_ptr increments. rd_ready while empty is ignored.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Pointers wrap naturally at 2^(AW+1).

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, last_grant=1 (so req0 wins the first tie). Outputs: empty=1, full=0, count=0, rd_valid=0, req*_ready=0, mem_w_en=0, almost_full=0.
- Reset asserted mid-operation clears all state immediately. Memory contents are not cleared here, but the FIFO is logically empty.
- Write-to-read latency: data pushed in cycle N appears with rd_valid=1 in cycle N+1.
- Full/empty/count update one cycle after the push/pop edge.
- Ready is combinational from valid and state; requesters must not make valid depend on ready.

## Configuration
- Macro TX_FIFO_CTRL_ALMOST_FULL_EN.
- Defined: almost_full port exists, registered, high when count (after the current cycle's update) ≥ AF_THRESHOLD.
- Undefined: port and logic are absent; AF_THRESHOLD is unused.

## Structure
- Package tx_fifo_pkg holds:
  - localparam for the pointer width helper
  - grant index typedef (REQ0=0, REQ1=1)
  - default AF_THRESHOLD offset
- Sub-module rr_arb2 implements the two-input round-robin grant and last_grant register. Instantiate once.
- The FIFO memory stays a separate instance driven by the mem_* ports.

## Test plan
- Reset then idle: empty=1, count=0, rd_valid=0, mem_w_en=0 after rst release.
- Both requesters valid continuously, rd_ready=0, depth 8: grants alternate 0,1,0,1…; full=1 after 8 pushes; both readies drop to 0.
- Full FIFO, rd_ready=1 with both requesters valid: pop occurs and no push that cycle. Next cycle count=7, then one push is granted.
- Push and pop every cycle for 20 cycles: count constant, pointers wrap past 8 and 16, data order matches push order.
- Async rst pulse mid-burst with count=5: count=0 and empty=1 immediately; the next push lands at address 0.
- With TX_FIFO_CTRL_ALMOST_FULL_EN and AF_THRESHOLD=6: almost_full rises in the cycle after the 6th push and falls after the pop to 5.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
// Shared types and helpers for the TX FIFO controller.
package tx_fifo_pkg;

  // Default almost-full distance from the top of the FIFO
  localparam int unsigned AF_OFFSET = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } grant_t;

  // Pointer width: address bits plus one wrap bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_fifo_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; last_grant only moves when a grant is consumed.
module rr_arb2
  import tx_fifo_pkg::*;
(
  input  logic   w_clk,
  input  logic   rst,
  input  logic   valid0,
  input  logic   valid1,
  input  logic   advance,
  output grant_t grant,
  output logic   grant_vld
);

  grant_t last_grant;

  // A tie goes to whichever requester was not served last
  always_comb begin
    grant     = REQ0;
    grant_vld = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (valid1) begin
      grant = REQ1;
    end
  end

  // Reset to REQ1 so requester 0 wins the first tie
  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ1;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/tx_fifo_ctrl.sv
// TX FIFO controller: arbitrates two writers onto the memory write port, owns pointers.
// Optional almost_full output enabled by TX_FIFO_CTRL_ALMOST_FULL_EN.
module tx_fifo_ctrl
  import tx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH = 8
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_THRESHOLD = FIFO_DEPTH - AF_OFFSET
`endif
) (
  input  logic                          w_clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [DATA_WIDTH-1:0]         req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [DATA_WIDTH-1:0]         req1_data,
  output logic                          req1_ready,
  output logic                          mem_w_en,
  output logic [$clog2(FIFO_DEPTH)-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0]         mem_w_data,
  output logic [$clog2(FIFO_DEPTH)-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0]         mem_r_data,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_ready,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
  ,
  output logic                          almost_full
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = ptr_w(FIFO_DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  grant_t        grant;
  logic          grant_vld;
  logic          push;
  logic          pop;

  rr_arb2 u_arb (
    .w_clk     (w_clk),
    .rst       (rst),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .advance   (push),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Occupancy decoded straight from the registered pointers
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // A full FIFO refuses writes even if the head is popped this cycle
  assign req0_ready = grant_vld && (grant == REQ0) && !full;
  assign req1_ready = grant_vld && (grant == REQ1) && !full;
  assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign mem_w_en   = push;
  assign mem_w_addr = wr_ptr[AW-1:0];
  assign mem_w_data = (grant == REQ1) ? req1_data : req0_data;

  assign mem_r_addr = rd_ptr[AW-1:0];
  assign rd_data    = mem_r_data;
  assign rd_valid   = !empty;
  assign pop        = rd_valid && rd_ready;

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
  logic [PW-1:0] count_nxt;

  // Flag reflects occupancy after this cycle's push/pop
  assign count_nxt = count + PW'(push) - PW'(pop);

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= PW'(AF_THRESHOLD));
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Scoreboard bench for tx_fifo_ctrl: queue-based reference model, random and directed stimulus.
module tb_tx_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF_TH = DEPTH - 2;

  logic       w_clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rd_ready;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       mem_w_en;
  logic [2:0] mem_w_addr, mem_r_addr;
  logic [7:0] mem_w_data, mem_r_data, rd_data;
  logic       rd_valid, full, empty;
  logic [3:0] count;
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
  logic       almost_full;
`endif

  tx_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .w_clk      (w_clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .full       (full),
    .empty      (empty),
    .count      (count)
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always #5 w_clk = ~w_clk;

  // FIFO storage instance, written by the controller, read combinationally
  logic [7:0] mem [DEPTH];
  always @(posedge w_clk) if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
  assign mem_r_data = mem[mem_r_addr];

  typedef struct {
    logic       r0, r1, wen;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [3:0] cnt;
    logic       emp, ful, rv;
    logic [7:0] rdata;
    logic       af;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         m_last;
  int         m_waddr;
  logic       m_af;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    m_last  = 1;
    m_waddr = 0;
    m_af    = 1'b0;
  endtask

  // Drive one cycle; record what the DUT must show this cycle, then advance the model
  task automatic step(input logic v0, input logic v1, input logic [7:0] d0,
                      input logic [7:0] d1, input logic rr);
    exp_t e;
    int   g;
    logic mfull, push, pop;
    @(negedge w_clk);
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; rd_ready = rr;
    mfull = (fifo_q.size() == DEPTH);
    g = -1;
    if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    push    = (g >= 0) && !mfull;
    e.r0    = push && (g == 0);
    e.r1    = push && (g == 1);
    e.wen   = push;
    e.waddr = 3'(m_waddr);
    e.wdata = (g == 1) ? d1 : d0;
    e.cnt   = 4'(fifo_q.size());
    e.emp   = (fifo_q.size() == 0);
    e.ful   = mfull;
    e.rv    = !e.emp;
    e.rdata = e.rv ? fifo_q[0] : 8'h00;
    e.af    = m_af;
    exp_q.push_back(e);
    pop = e.rv && rr;
    if (pop) void'(fifo_q.pop_front());
    if (push) begin
      fifo_q.push_back(e.wdata);
      m_waddr = (m_waddr + 1) % DEPTH;
      m_last  = g;
    end
    m_af = (fifo_q.size() >= AF_TH);
  endtask

  // Monitor: compare every recorded cycle once inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge w_clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req0_ready", 32'(req0_ready), 32'(e.r0));
        chk("req1_ready", 32'(req1_ready), 32'(e.r1));
        chk("mem_w_en",   32'(mem_w_en),   32'(e.wen));
        if (e.wen) begin
          chk("mem_w_addr", 32'(mem_w_addr), 32'(e.waddr));
          chk("mem_w_data", 32'(mem_w_data), 32'(e.wdata));
        end
        chk("count",    32'(count),    32'(e.cnt));
        chk("empty",    32'(empty),    32'(e.emp));
        chk("full",     32'(full),     32'(e.ful));
        chk("rd_valid", 32'(rd_valid), 32'(e.rv));
        if (e.rv) chk("rd_data", 32'(rd_data), 32'(e.rdata));
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(e.af));
`endif
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_count"},    32'(count),      32'd0);
    chk({tag, "_empty"},    32'(empty),      32'd1);
    chk({tag, "_full"},     32'(full),       32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),   32'd0);
    chk({tag, "_mem_w_en"}, 32'(mem_w_en),   32'd0);
    chk({tag, "_ready0"},   32'(req0_ready), 32'd0);
    chk({tag, "_ready1"},   32'(req1_ready), 32'd0);
`ifdef TX_FIFO_CTRL_ALMOST_FULL_EN
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    model_reset();
    repeat (3) @(negedge w_clk);
    #1 rst = 1'b1;
    @(negedge w_clk);
    #3 chk_idle("reset");

    // Fill with both requesters contending: grants alternate, then both stall
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);

    // Full with a pop: no push that cycle, then one push once space exists
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);

    // Free one slot, then push and pop together for 20 cycles across pointer wrap
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
      else                           step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    // Drain, refill to 5, then reset asynchronously mid-cycle
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0);
    @(negedge w_clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
    #3 chk("pre_reset_count", 32'(count), 32'd5);
    rst = 1'b0;
    #1 chk_idle("async_reset");
    model_reset();
    @(negedge w_clk);
    #1 rst = 1'b1;
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    @(negedge w_clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
    #4;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
